adder_result_checker: RTL and testbench

- Receiving end of the adder test harness: watches the stimulus applied to a pipelined adder DUT and the DUT's sum output, and checks every result against an internally computed expected value.
- The expected value travels through a delay line matched to the DUT latency.
- Counts checks and mismatches, captures the first failing vector, and reports pass/fail when a programmed number of checks has completed.
- Sits beside the stimulus master in the adder bench; synthesizable so it can also be used on FPGA.

---
 rtl/adder_result_checker_pkg.sv | 15 +
 rtl/adder_result_checker_if.sv | 36 +++
 rtl/adder_result_checker_expected_delay_line.sv | 44 ++++
 rtl/adder_result_checker.sv | 163 ++++++++++++++++
 tb/tb_adder_result_checker.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_result_checker_pkg.sv
// Shared types and default constants for the adder result checker and the
// stimulus master that sits beside it in the adder bench.
package adder_result_checker_pkg;

    localparam int DEF_INP_DW  = 3;
    localparam int DEF_LATENCY = 2;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/adder_result_checker_if.sv
// Bundle of stimulus observation, DUT result and run-status signals between
// the adder bench (master) and the result checker (slave).
interface adder_result_checker_if
    import adder_result_checker_pkg::*;
#(
    parameter int INP_DW = DEF_INP_DW,
    parameter int CNT_W  = DEF_CNT_W
) ();

    logic              start;
    logic [CNT_W-1:0]  num_checks;
    logic              in_valid;
    logic [INP_DW-1:0] inp_a;
    logic [INP_DW-1:0] inp_b;
    logic [INP_DW:0]   dut_sum;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  check_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic [INP_DW-1:0] err_a;
    logic [INP_DW-1:0] err_b;
    logic [INP_DW:0]   err_exp;
    logic [INP_DW:0]   err_got;

    modport master (
        output start, num_checks, in_valid, inp_a, inp_b, dut_sum,
        input  busy, done, pass, check_cnt, err_cnt, err_a, err_b, err_exp, err_got
    );

    modport slave (
        input  start, num_checks, in_valid, inp_a, inp_b, dut_sum,
        output busy, done, pass, check_cnt, err_cnt, err_a, err_b, err_exp, err_got
    );

endinterface

// File: rtl/adder_result_checker_expected_delay_line.sv
// Valid+payload shift register matching the adder pipeline depth; valids have
// an asynchronous active-low reset and a synchronous clear.
module expected_delay_line #(
    parameter int WIDTH   = 10,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [LATENCY-1:0] valid_q;
    logic [WIDTH-1:0]   data_q [LATENCY];

    // Valid bits: cleared on reset or at the start of a run, otherwise shifted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (clr_i) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Payload only matters when its valid bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        data_q[0] <= data_i;
        for (int i = 1; i < LATENCY; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/adder_result_checker.sv
// Checks a pipelined adder's sums against operand sums delayed by LATENCY.
// Build option ADDER_CHECK_STOP_ON_ERR_EN: the first mismatch ends the run.
module adder_result_checker
    import adder_result_checker_pkg::*;
#(
    parameter int INP_DW  = DEF_INP_DW,
    parameter int LATENCY = DEF_LATENCY,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    adder_result_checker_if.slave  bus
);

    localparam int SUM_W = INP_DW + 1;
    localparam int PAY_W = SUM_W + 2 * INP_DW;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [CNT_W-1:0]  check_cnt_q, check_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [INP_DW-1:0] err_a_q, err_a_d, err_b_q, err_b_d;
    logic [SUM_W-1:0]  err_exp_q, err_exp_d, err_got_q, err_got_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;

    logic [SUM_W-1:0]  exp_s;
    logic              dl_clr_s, dl_valid_s, tap_valid_s, mismatch_s, stop_s;
    logic [PAY_W-1:0]  tap_data_s;
    logic [SUM_W-1:0]  tap_exp_s;
    logic [INP_DW-1:0] tap_a_s, tap_b_s;

    assign exp_s      = {1'b0, bus.inp_a} + {1'b0, bus.inp_b};
    assign dl_clr_s   = bus.start && (state_q != ST_RUN);
    assign dl_valid_s = bus.in_valid && (state_q == ST_RUN);

    expected_delay_line #(
        .WIDTH   (PAY_W),
        .LATENCY (LATENCY)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (dl_clr_s),
        .valid_i (dl_valid_s),
        .data_i  ({exp_s, bus.inp_a, bus.inp_b}),
        .valid_o (tap_valid_s),
        .data_o  (tap_data_s)
    );

    assign {tap_exp_s, tap_a_s, tap_b_s} = tap_data_s;
    assign mismatch_s = (tap_exp_s != bus.dut_sum);

`ifdef ADDER_CHECK_STOP_ON_ERR_EN
    assign stop_s = mismatch_s;
`else
    assign stop_s = 1'b0;
`endif

    // Run control, counting and first-mismatch capture.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        check_cnt_d = check_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_a_d     = err_a_q;
        err_b_d     = err_b_q;
        err_exp_d   = err_exp_q;
        err_got_d   = err_got_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d     = ST_RUN;
                    target_d    = bus.num_checks;
                    check_cnt_d = '0;
                    err_cnt_d   = '0;
                    err_a_d     = '0;
                    err_b_d     = '0;
                    err_exp_d   = '0;
                    err_got_d   = '0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (check_cnt_q >= target_q) begin
                    state_d = ST_DONE;
                end else if (tap_valid_s) begin
                    check_cnt_d = check_cnt_q + CNT_W'(1);
                    if (mismatch_s) begin
                        if (err_cnt_q != {CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                        // A zero error count marks this as the run's first mismatch.
                        if (err_cnt_q == '0) begin
                            err_a_d   = tap_a_s;
                            err_b_d   = tap_b_s;
                            err_exp_d = tap_exp_s;
                            err_got_d = bus.dut_sum;
                        end else begin
                            err_a_d = err_a_q;
                        end
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    if ((check_cnt_d == target_q) || stop_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (err_cnt_d == '0);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            check_cnt_q <= '0;
            err_cnt_q   <= '0;
            err_a_q     <= '0;
            err_b_q     <= '0;
            err_exp_q   <= '0;
            err_got_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            check_cnt_q <= check_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_a_q     <= err_a_d;
            err_b_q     <= err_b_d;
            err_exp_q   <= err_exp_d;
            err_got_q   <= err_got_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.check_cnt = check_cnt_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.err_a     = err_a_q;
    assign bus.err_b     = err_b_q;
    assign bus.err_exp   = err_exp_q;
    assign bus.err_got   = err_got_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker: a pipelined adder stand-in with
// fault injection, a queue-based reference model and literal spot checks.
module tb_adder_result_checker;

    localparam int LAT = 2;
`ifdef ADDER_CHECK_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct {
        int         due;
        logic [2:0] a;
        logic [2:0] b;
        logic [3:0] s;
    } ent_t;

    logic clk;
    logic rst;
    int   cyc;
    logic corrupt;
    logic [3:0] pipe [LAT];

    int n_chk;
    int n_pass;
    int t10;
    int done_cyc;
    int nv;

    // reference model state
    bit          m_run, m_busy, m_done, m_pass, m_end;
    logic [15:0] m_tgt, m_chk, m_err;
    logic [2:0]  m_ea, m_eb;
    logic [3:0]  m_eexp, m_egot;
    ent_t        q[$];
    ent_t        m_e;

    adder_result_checker_if #(.INP_DW(3), .CNT_W(16)) bus ();

    adder_result_checker #(
        .INP_DW  (3),
        .LATENCY (LAT),
        .CNT_W   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // adder under test: operands sampled on the edge, sum LAT clocks later
    always @(posedge clk) begin
        pipe[0] <= corrupt ? 4'd0 : ({1'b0, bus.inp_a} + {1'b0, bus.inp_b});
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.dut_sum = pipe[LAT-1];

    // Reference: each accepted sample becomes a check due LAT cycles later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run = 1'b0; m_done = 1'b0; m_pass = 1'b0;
            m_tgt = 16'd0; m_chk = 16'd0; m_err = 16'd0;
            m_ea = 3'd0; m_eb = 3'd0; m_eexp = 4'd0; m_egot = 4'd0;
            q.delete();
        end else if (m_run) begin
            m_end = 1'b0;
            if (m_chk >= m_tgt) begin
                m_end = 1'b1;
            end else if (q.size() > 0 && q[0].due == cyc) begin
                m_e = q.pop_front();
                m_chk = m_chk + 16'd1;
                if (m_e.s != bus.dut_sum) begin
                    if (m_err == 16'd0) begin
                        m_ea = m_e.a; m_eb = m_e.b; m_eexp = m_e.s; m_egot = bus.dut_sum;
                    end
                    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                    if (STOP) m_end = 1'b1;
                end
                if (m_chk == m_tgt) m_end = 1'b1;
            end
            if (bus.in_valid)
                q.push_back('{cyc + LAT, bus.inp_a, bus.inp_b, {1'b0, bus.inp_a} + {1'b0, bus.inp_b}});
            if (m_end) begin
                m_run = 1'b0; m_done = 1'b1; m_pass = (m_err == 16'd0);
                q.delete();
            end
        end else if (bus.start) begin
            m_run = 1'b1; m_done = 1'b0; m_pass = 1'b0;
            m_tgt = bus.num_checks; m_chk = 16'd0; m_err = 16'd0;
            m_ea = 3'd0; m_eb = 3'd0; m_eexp = 4'd0; m_egot = 4'd0;
            q.delete();
        end
        m_busy = m_run;
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        cmp("busy", 32'(bus.busy), 32'(m_busy));
        cmp("done", 32'(bus.done), 32'(m_done));
        cmp("pass", 32'(bus.pass), 32'(m_pass));
        cmp("check_cnt", 32'(bus.check_cnt), 32'(m_chk));
        cmp("err_cnt", 32'(bus.err_cnt), 32'(m_err));
        cmp("err_a", 32'(bus.err_a), 32'(m_ea));
        cmp("err_b", 32'(bus.err_b), 32'(m_eb));
        cmp("err_exp", 32'(bus.err_exp), 32'(m_eexp));
        cmp("err_got", 32'(bus.err_got), 32'(m_egot));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] a, input logic [2:0] b, input logic bad);
        bus.in_valid = v; bus.inp_a = a; bus.inp_b = b; corrupt = bad;
        tick();
    endtask

    task automatic pulse_start(input logic [15:0] n);
        bus.start = 1'b1; bus.num_checks = n;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        bus.in_valid = 1'b0; corrupt = 1'b0;
        while (!bus.done && k < budget) begin
            tick();
            k++;
        end
        cmp("done_timeout", 32'(bus.done), 32'd1);
    endtask

    initial begin
        logic [5:0] idx;
        logic [2:0] a, b;
        n_chk = 0; n_pass = 0; cyc = 0; corrupt = 1'b0;
        rst = 1'b0;
        bus.start = 1'b0; bus.num_checks = 16'd0; bus.in_valid = 1'b0;
        bus.inp_a = 3'd0; bus.inp_b = 3'd0;
        repeat (3) tick();
        rst = 1'b1;

        // idle after reset; in_valid alone must not count
        for (int i = 0; i < 20; i++) drive(i[0], 3'd7, 3'd7, 1'b0);
        cmp("idle_busy", 32'(bus.busy), 32'd0);
        cmp("idle_done", 32'(bus.done), 32'd0);
        cmp("idle_check", 32'(bus.check_cnt), 32'd0);

        // exhaustive, correct adder
        pulse_start(16'd64);
        for (int i = 0; i < 64; i++) begin
            idx = 6'(i);
            drive(1'b1, idx[5:3], idx[2:0], 1'b0);
        end
        wait_done(20);
        cmp("ex_check", 32'(bus.check_cnt), 32'd64);
        cmp("ex_err", 32'(bus.err_cnt), 32'd0);
        cmp("ex_pass", 32'(bus.pass), 32'd1);
        repeat (3) tick();
        cmp("ex_done_held", 32'(bus.done), 32'd1);

        // exhaustive, adder returns 0 for 5+3
        pulse_start(16'd64);
        for (int i = 0; i < 64; i++) begin
            idx = 6'(i);
            drive(1'b1, idx[5:3], idx[2:0], (idx[5:3] == 3'd5) && (idx[2:0] == 3'd3));
        end
        wait_done(20);
        cmp("f_err", 32'(bus.err_cnt), 32'd1);
        cmp("f_err_a", 32'(bus.err_a), 32'd5);
        cmp("f_err_b", 32'(bus.err_b), 32'd3);
        cmp("f_err_exp", 32'(bus.err_exp), 32'd8);
        cmp("f_err_got", 32'(bus.err_got), 32'd0);
        cmp("f_pass", 32'(bus.pass), 32'd0);
        cmp("f_check", 32'(bus.check_cnt), 32'd64);

        // in_valid on alternate cycles, extra samples and a start during the run
        pulse_start(16'd10);
        nv = 0; t10 = -1; done_cyc = -1;
        for (int i = 0; i < 30; i++) begin
            if (i == 4) begin bus.start = 1'b1; bus.num_checks = 16'd3; end
            else bus.start = 1'b0;
            if (i % 2 == 0) begin
                nv++;
                if (nv == 10) t10 = cyc;
            end
            drive(i % 2 == 0, 3'(i), 3'(7 - i % 8), 1'b0);
            if (bus.done && done_cyc < 0) done_cyc = cyc;
        end
        bus.start = 1'b0;
        cmp("gap_check", 32'(bus.check_cnt), 32'd10);
        cmp("gap_done_lat", 32'(done_cyc - (t10 + 1)), 32'(LAT));
        cmp("gap_pass", 32'(bus.pass), 32'd1);

        // empty run finishes one clock after entering RUN
        pulse_start(16'd0);
        tick();
        cmp("zero_done", 32'(bus.done), 32'd1);
        cmp("zero_pass", 32'(bus.pass), 32'd1);
        cmp("zero_check", 32'(bus.check_cnt), 32'd0);

        // errors at the 3rd and 7th check
        pulse_start(16'd10);
        for (int i = 0; i < 10; i++) begin
            a = 3'((i % 7) + 1);
            b = 3'((i * 3) % 8);
            drive(1'b1, a, b, (i == 2) || (i == 6));
        end
        wait_done(20);
        cmp("se_err_a", 32'(bus.err_a), 32'd3);
        cmp("se_err_got", 32'(bus.err_got), 32'd0);
        cmp("se_err_exp", 32'(bus.err_exp), 32'd9);
`ifdef ADDER_CHECK_STOP_ON_ERR_EN
        cmp("se_check", 32'(bus.check_cnt), 32'd3);
        cmp("se_err", 32'(bus.err_cnt), 32'd1);
`else
        cmp("se_check", 32'(bus.check_cnt), 32'd10);
        cmp("se_err", 32'(bus.err_cnt), 32'd2);
`endif

        // asynchronous reset in the middle of a long run
        pulse_start(16'd100);
        for (int i = 0; i < 6; i++) drive(1'b1, 3'd6, 3'd7, i == 1);
        cmp("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        cmp("rst_busy", 32'(bus.busy), 32'd0);
        cmp("rst_done", 32'(bus.done), 32'd0);
        cmp("rst_check", 32'(bus.check_cnt), 32'd0);
        cmp("rst_err", 32'(bus.err_cnt), 32'd0);
        cmp("rst_err_a", 32'(bus.err_a), 32'd0);
        bus.in_valid = 1'b0; corrupt = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
